// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: scan states,
// digit width and the all-off digit select.
package seg7_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] BLANK_SEL = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Core-facing bundle of the scan controller: enable, register-file write
// port and the display outputs toward the shared seg7 decoder.
interface seg7_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                         en;
    logic                         wr_en;
    logic [AW-1:0]                wr_addr;
    logic [seg7_pkg::DIGIT_W-1:0] wr_data;
    logic [seg7_pkg::DIGIT_W-1:0] digit_value;
    logic [NUM_DIGITS-1:0]        digit_sel;
    logic [AW-1:0]                scan_idx;
    logic                         frame_done;

    modport master (
        output en, wr_en, wr_addr, wr_data,
        input  digit_value, digit_sel, scan_idx, frame_done
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data,
        output digit_value, digit_sel, scan_idx, frame_done
    );

endinterface

// File: rtl/seg7_scan_timer.sv
// Phase counter for the scan sequencer with clear/increment and
// terminal-count flags for the guard and dwell intervals.
module seg7_scan_timer #(
    parameter int unsigned DWELL_CYC = 10000,
    parameter int unsigned GUARD_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic guard_tc_c,
    output logic dwell_tc_c
);
    localparam int unsigned MAX_CYC = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic [CW-1:0] cnt;

    // Clear wins over increment so every new phase starts at zero
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign guard_tc_c = (cnt == CW'(GUARD_CYC - 1));
    assign dwell_tc_c = (cnt == CW'(DWELL_CYC - 1));

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: digit register file, guard/drive
// sequencing and one-hot select. Define SEG7_SCAN_LZB_EN for leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DWELL_CYC  = 10000,
    parameter int unsigned GUARD_CYC  = 16
) (
    input  logic            clk,
    input  logic            rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int unsigned AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] SEL_BLANK = BLANK_SEL[NUM_DIGITS-1:0];

    scan_state_e           state, state_nxt;
    logic [DIGIT_W-1:0]    regs    [NUM_DIGITS];
    logic [DIGIT_W-1:0]    regs_wf [NUM_DIGITS];
    logic [DIGIT_W-1:0]    cur_val_c;
    logic [AW-1:0]         scan_idx, scan_idx_nxt;
    logic [NUM_DIGITS-1:0] digit_sel, digit_sel_nxt;
    logic [DIGIT_W-1:0]    digit_value, digit_value_nxt;
    logic                  frame_done, frame_done_nxt;
    logic                  wr_ok_c, last_digit_c, lz_blank_c;
    logic                  guard_tc_c, dwell_tc_c, cnt_clr_c, cnt_inc_c;

    assign wr_ok_c      = bus.wr_en && (32'(bus.wr_addr) < NUM_DIGITS);
    assign last_digit_c = (scan_idx == AW'(NUM_DIGITS - 1));

    // Write-first view of the register file, so a write on the latch edge is displayed
    always_comb begin
        cur_val_c = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            regs_wf[i] = regs[i];
            if (wr_ok_c && (bus.wr_addr == AW'(i))) begin
                regs_wf[i] = bus.wr_data;
            end
            if (scan_idx == AW'(i)) begin
                cur_val_c = regs_wf[i];
            end
        end
    end

`ifdef SEG7_SCAN_LZB_EN
    // Blank when this digit and every more-significant digit are zero; digit 0 always shows
    always_comb begin
        lz_blank_c = (scan_idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((AW'(i) >= scan_idx) && (regs_wf[i] != '0)) begin
                lz_blank_c = 1'b0;
            end
        end
    end
`else
    assign lz_blank_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                regs[i] <= regs_wf[i];
            end
        end
    end

    seg7_scan_timer #(
        .DWELL_CYC (DWELL_CYC),
        .GUARD_CYC (GUARD_CYC)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr_c),
        .inc        (cnt_inc_c),
        .guard_tc_c (guard_tc_c),
        .dwell_tc_c (dwell_tc_c)
    );

    assign cnt_clr_c = (state_nxt != state);
    assign cnt_inc_c = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            scan_idx    <= '0;
            digit_sel   <= SEL_BLANK;
            digit_value <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            scan_idx    <= scan_idx_nxt;
            digit_sel   <= digit_sel_nxt;
            digit_value <= digit_value_nxt;
            frame_done  <= frame_done_nxt;
        end
    end

    // Next-state and next-output logic; dropping en aborts to IDLE from any state
    always_comb begin
        state_nxt       = state;
        scan_idx_nxt    = scan_idx;
        digit_sel_nxt   = digit_sel;
        digit_value_nxt = digit_value;
        frame_done_nxt  = 1'b0;
        if (!bus.en) begin
            state_nxt     = ST_IDLE;
            scan_idx_nxt  = '0;
            digit_sel_nxt = SEL_BLANK;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_GUARD;
                end
                ST_GUARD: begin
                    if (guard_tc_c) begin
                        state_nxt       = ST_DRIVE;
                        digit_value_nxt = cur_val_c;
                        digit_sel_nxt   = lz_blank_c ? SEL_BLANK : (NUM_DIGITS'(1) << scan_idx);
                    end
                end
                ST_DRIVE: begin
                    if (dwell_tc_c) begin
                        state_nxt      = ST_GUARD;
                        digit_sel_nxt  = SEL_BLANK;
                        frame_done_nxt = last_digit_c;
                        scan_idx_nxt   = last_digit_c ? '0 : scan_idx + AW'(1);
                    end
                end
                default: begin
                    state_nxt     = ST_IDLE;
                    scan_idx_nxt  = '0;
                    digit_sel_nxt = SEL_BLANK;
                end
            endcase
        end
    end

    assign bus.digit_value = digit_value;
    assign bus.digit_sel   = digit_sel;
    assign bus.scan_idx    = scan_idx;
    assign bus.frame_done  = frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl against a frame-position reference model.
// Honours SEG7_SCAN_LZB_EN when defined.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int G     = 2;
    localparam int SLOT  = G + D;
    localparam int FRAME = N * SLOT;
    localparam int N2    = 6;

    logic clk = 1'b0;
    logic rst;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N))  bus ();
    seg7_scan_ctrl_if #(.NUM_DIGITS(N2)) bus2 ();

    seg7_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYC(D), .GUARD_CYC(G)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(N2), .DWELL_CYC(D), .GUARD_CYC(G)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the frame decides everything
    int m_regs [N];
    int m_p     = -1;
    int m_val   = 0;
    int m_sel   = 0;
    int m_idx   = 0;
    int m_fd    = 0;
    bit m_blank = 1'b0;

    function automatic bit lzb_blank(input int r [N], input int k);
        bit b = (k != 0);
        for (int j = k; j < N; j++) if (r[j] != 0) b = 1'b0;
`ifndef SEG7_SCAN_LZB_EN
        b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic [10:0] dut_out();
        return {bus.digit_sel, bus.digit_value, bus.scan_idx, bus.frame_done};
    endfunction

    function automatic logic [10:0] model_out();
        return {4'(m_sel), 4'(m_val), 2'(m_idx), 1'(m_fd)};
    endfunction

    function automatic int m_digit();
        return (m_p < 0) ? -1 : (m_p % FRAME) / SLOT;
    endfunction

    function automatic int m_within();
        return (m_p < 0) ? -1 : m_p % SLOT;
    endfunction

    task automatic tick();
        int nregs [N];
        int f, k, w;
        @(posedge clk);
        nregs = m_regs;
        if (rst) begin
            m_regs = '{default: 0};
            m_p = -1; m_val = 0; m_sel = 0; m_idx = 0; m_fd = 0; m_blank = 1'b0;
        end else begin
            if (bus.wr_en && int'(bus.wr_addr) < N) nregs[bus.wr_addr] = int'(bus.wr_data);
            if (!bus.en) begin
                m_p = -1; m_sel = 0; m_idx = 0; m_fd = 0;
            end else begin
                m_p++;
                f = m_p % FRAME;
                k = f / SLOT;
                w = f % SLOT;
                if (w == G) begin
                    m_val   = nregs[k];
                    m_blank = lzb_blank(nregs, k);
                end
                m_sel = (w >= G && !m_blank) ? (1 << k) : 0;
                m_idx = k;
                m_fd  = (f == 0 && m_p > 0) ? 1 : 0;
            end
            m_regs = nregs;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus2.en = 1'b0; bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
        repeat (3) begin
            tick();
            checks++;
            if (dut_out() !== 11'd0) begin
                errors++; $display("FAIL reset got %b exp %b", dut_out(), 11'd0);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dut_out() !== 11'd0) begin
            errors++; $display("FAIL reset_idle got %b exp %b", dut_out(), 11'd0);
        end
    endtask

    task automatic test_frames();
        int fd_cnt = 0;
        for (int i = 0; i < N; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 2'(i); bus.wr_data = 4'(i + 1);
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL frames_wr got %b exp %b", dut_out(), model_out());
            end
        end
        bus.wr_en = 1'b0;
        bus.en = 1'b1;
        for (int c = 0; c < 2 * FRAME + 1; c++) begin
            tick();
            if (bus.frame_done === 1'b1) fd_cnt++;
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL frames p=%0d got %b exp %b", m_p, dut_out(), model_out());
            end
        end
        checks++;
        if (fd_cnt !== 2) begin
            errors++; $display("FAIL frame_done_count got %0d exp %0d", fd_cnt, 2);
        end
    endtask

    task automatic test_write_during_drive();
        bit hit = 1'b0;
        int seen9 = 0;
        for (int c = 0; c < 2 * FRAME && !hit; c++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL wr_drive_seek got %b exp %b", dut_out(), model_out());
            end
            hit = (m_digit() == 1) && (m_within() == G + 1);
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL wr_drive_timeout got %0d exp %0d", 0, 1);
        end
        bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 4'd9;
        tick();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.digit_value !== 4'd2) begin
            errors++; $display("FAIL wr_drive_hold got %h exp %h", bus.digit_value, 4'd2);
        end
        for (int c = 0; c < FRAME + SLOT; c++) begin
            tick();
            if (bus.digit_sel === 4'b0010 && bus.digit_value === 4'd9) seen9++;
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL wr_drive p=%0d got %b exp %b", m_p, dut_out(), model_out());
            end
        end
        checks++;
        if (seen9 !== D) begin
            errors++; $display("FAIL wr_drive_next got %0d exp %0d", seen9, D);
        end
    endtask

    task automatic test_en_drop();
        bit hit = 1'b0;
        for (int c = 0; c < 2 * FRAME && !hit; c++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL en_drop_seek got %b exp %b", dut_out(), model_out());
            end
            hit = (m_digit() == 2) && (m_within() == G + 1);
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL en_drop_timeout got %0d exp %0d", 0, 1);
        end
        bus.en = 1'b0;
        tick();
        checks++;
        if (bus.digit_sel !== 4'b0000 || bus.scan_idx !== 2'd0 || bus.digit_value !== 4'd3
            || bus.frame_done !== 1'b0) begin
            errors++; $display("FAIL en_drop got %b exp %b", dut_out(), {4'b0000, 4'd3, 2'd0, 1'b0});
        end
        bus.en = 1'b1;
        for (int c = 0; c < G + 1; c++) begin
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL en_restart got %b exp %b", dut_out(), model_out());
            end
        end
        checks++;
        if (bus.digit_sel !== 4'b0001 || bus.digit_value !== 4'd1) begin
            errors++; $display("FAIL en_restart_d0 got %b/%h exp %b/%h",
                               bus.digit_sel, bus.digit_value, 4'b0001, 4'd1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.wr_en   = ($urandom_range(3, 0) == 0);
            bus.wr_addr = 2'($urandom_range(N - 1, 0));
            bus.wr_data = 4'($urandom_range(15, 0));
            bus.en      = ($urandom_range(39, 0) != 0);
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL random c=%0d got %b exp %b", c, dut_out(), model_out());
            end
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_rst_mid();
        int nz = 0;
        bus.en = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dut_out() !== 11'd0) begin
            errors++; $display("FAIL rst_mid got %b exp %b", dut_out(), 11'd0);
        end
        for (int c = 0; c < FRAME + 1; c++) begin
            tick();
            if (bus.digit_sel !== 4'b0000 && bus.digit_value !== 4'd0) nz++;
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL rst_frame got %b exp %b", dut_out(), model_out());
            end
        end
        checks++;
        if (nz !== 0) begin
            errors++; $display("FAIL rst_regs got %0d exp %0d", nz, 0);
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0] exp2 [N2];
        int k, w;
        logic [5:0] esel;
        for (int i = 0; i < N2; i++) begin
            exp2[i] = 4'($urandom_range(15, 1));
            bus2.wr_en = 1'b1; bus2.wr_addr = 3'(i); bus2.wr_data = exp2[i];
            tick();
        end
        for (int a = N2; a < 8; a++) begin
            bus2.wr_addr = 3'(a); bus2.wr_data = 4'($urandom_range(15, 1));
            tick();
        end
        bus2.wr_en = 1'b0;
        bus2.en = 1'b1;
        for (int p = 0; p < N2 * SLOT; p++) begin
            tick();
            k = p / SLOT;
            w = p % SLOT;
            esel = (w >= G) ? 6'(1 << k) : 6'd0;
            checks++;
            if (bus2.digit_sel !== esel || (w >= G && bus2.digit_value !== exp2[k])) begin
                errors++; $display("FAIL oor p=%0d got %b/%h exp %b/%h",
                                   p, bus2.digit_sel, bus2.digit_value, esel, exp2[k]);
            end
        end
        bus2.en = 1'b0;
    endtask

    task automatic test_lzb();
        int drv [N];
        int exp_drv [N];
        int vals [N];
        vals = '{0, 7, 0, 0};
        drv  = '{default: 0};
`ifdef SEG7_SCAN_LZB_EN
        exp_drv = '{D, D, 0, 0};
`else
        exp_drv = '{D, D, D, D};
`endif
        bus.en = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 2'(i); bus.wr_data = 4'(vals[i]);
            tick();
        end
        bus.wr_en = 1'b0;
        bus.en = 1'b1;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            for (int k = 0; k < N; k++) if (bus.digit_sel === 4'(1 << k)) drv[k]++;
            checks++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL lzb p=%0d got %b exp %b", m_p, dut_out(), model_out());
            end
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (drv[k] !== exp_drv[k]) begin
                errors++; $display("FAIL lzb_digit%0d got %0d exp %0d", k, drv[k], exp_drv[k]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got %0d exp %0d", 0, 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_frames();
        test_write_during_drive();
        test_en_drop();
        test_random();
        test_rst_mid();
        test_out_of_range();
        test_lzb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
